cmp_result_tally: RTL

//   Downstream consumer of the 4-bit magnitude comparator's 3-bit result R.

---
 rtl/cmp_tally_pkg.sv | 19 +
 rtl/sat_counter.sv | 34 +++
 rtl/cmp_result_tally.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cmp_tally_pkg.sv
// Shared constants for the comparator result tally:
// FSM states, result bit positions and one-hot result codes.
package cmp_tally_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE    = 2'd0;
   localparam state_t COLLECT = 2'd1;
   localparam state_t REPORT  = 2'd2;

   localparam int R_GT = 2;
   localparam int R_EQ = 1;
   localparam int R_LT = 0;

   localparam logic [2:0] CODE_GT = 3'b1 << R_GT;
   localparam logic [2:0] CODE_EQ = 3'b1 << R_EQ;
   localparam logic [2:0] CODE_LT = 3'b1 << R_LT;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cmp_result_tally.sv
// Collects 3-bit comparator results over a window and holds
// a GT/EQ/LT/illegal tally plus longest EQ run until acknowledged.
module cmp_result_tally
   import cmp_tally_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int RUN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dump,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_r,
   output logic             rpt_valid,
   input  logic             rpt_ack,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] lt_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [RUN_W-1:0] max_eq_run
);

   state_t state_q;
   state_t state_d;

   logic             is_gt;
   logic             is_eq;
   logic             is_lt;
   logic             is_err;
   logic             accept;
   logic             clr;
   logic             upd;
   logic [RUN_W-1:0] cur_run;
   logic [RUN_W-1:0] run_nxt;
   logic [RUN_W-1:0] max_q;
   logic [RUN_W-1:0] max_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = COLLECT;
         COLLECT: if (!start && dump) state_d = REPORT;
         REPORT:  if (rpt_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Both handshake outputs decode the state register only.
   always_comb begin
      in_ready  = (state_q == COLLECT);
      rpt_valid = (state_q == REPORT);
   end

   assign is_gt  = (in_r == CODE_GT);
   assign is_eq  = (in_r == CODE_EQ);
   assign is_lt  = (in_r == CODE_LT);
   assign is_err = !(is_gt || is_eq || is_lt);

   assign accept = in_valid && in_ready;
   assign clr    = start && (state_q != REPORT);
   // A restart drops the sample presented in the same cycle.
   assign upd    = accept && !start;

   assign run_nxt = (cur_run == '1) ? cur_run : cur_run + RUN_W'(1);

   always_comb begin
      max_d = max_q;
      if (clr) begin
         max_d = '0;
      end else if (upd && is_eq && (run_nxt > max_q)) begin
         max_d = run_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         max_q <= '0;
      end else begin
         max_q <= max_d;
      end
   end

   assign max_eq_run = max_q;

   sat_counter #(.W(CNT_W)) u_gt (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (clr),
      .inc_i (upd && is_gt),
      .cnt_o (gt_cnt)
   );

   sat_counter #(.W(CNT_W)) u_eq (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (clr),
      .inc_i (upd && is_eq),
      .cnt_o (eq_cnt)
   );

   sat_counter #(.W(CNT_W)) u_lt (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (clr),
      .inc_i (upd && is_lt),
      .cnt_o (lt_cnt)
   );

   sat_counter #(.W(CNT_W)) u_err (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (clr),
      .inc_i (upd && is_err),
      .cnt_o (err_cnt)
   );

   sat_counter #(.W(RUN_W)) u_run (
      .clk_i (clk),
      .rst_i (rst),
      .clr_i (clr || (upd && !is_eq)),
      .inc_i (upd && is_eq),
      .cnt_o (cur_run)
   );

endmodule
